// File: rtl/k_and_s_pkg.sv
// Shared K&S types: the instruction class the datapath decodes for the control FSM.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
  } decoded_instruction_type;
endpackage

// File: rtl/ks_datapath_param_if.sv
// Control/status and RAM bus between the K&S control FSM, the datapath and program/data RAM.
interface ks_datapath_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  import k_and_s_pkg::*;

  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       data_out;
  logic [DATA_W-1:0]       data_in;

  modport master (
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, data_in,
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

  modport slave (
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, data_in,
    output decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );
endinterface

// File: rtl/ks_datapath_param.sv
// Parametrised K&S datapath: IR, PC, register file, 4-op ALU, C-bus mux, flags, decoder.
module ks_datapath_param
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  ks_datapath_param_if.slave bus
);
  localparam int RW      = $clog2(NREGS);
  localparam int FIELD_W = (ADDR_W + RW > 3 * RW) ? ADDR_W + RW : 3 * RW;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  if (8 + FIELD_W > DATA_W || NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_param_check
    $error("ks_datapath_param: illegal DATA_W/NREGS/ADDR_W combination");
  end

  logic [DATA_W-1:0]       ir;
  logic [ADDR_W-1:0]       pc;
  logic [DATA_W-1:0]       regs [NREGS];
  logic                    zero_q, neg_q, uov_q, sov_q;

  logic [7:0]              opcode;
  decoded_instruction_type decoded;
  logic [RW-1:0]           a_addr, b_addr, c_addr;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       bus_a, bus_b, bus_c;
  logic [DATA_W-1:0]       b_op, alu_res;
  logic [DATA_W:0]         sum;
  logic                    is_sub, alu_z, alu_n, alu_u, alu_s;

  assign opcode = ir[DATA_W-1 -: 8];

  always_comb begin
    decoded  = I_NOP;
    a_addr   = '0;
    b_addr   = '0;
    c_addr   = '0;
    mem_addr = '0;
    case (opcode)
      8'h81: begin decoded = I_LOAD;  c_addr = ir[ADDR_W +: RW]; mem_addr = ir[ADDR_W-1:0]; end
      8'h82: begin decoded = I_STORE; a_addr = ir[ADDR_W +: RW]; mem_addr = ir[ADDR_W-1:0]; end
      8'h91: begin
        decoded = I_MOVE;
        a_addr  = ir[0 +: RW];
        b_addr  = ir[0 +: RW];
        c_addr  = ir[RW +: RW];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        case (opcode[2:0])
          3'd1:    decoded = I_ADD;
          3'd2:    decoded = I_SUB;
          3'd3:    decoded = I_AND;
          default: decoded = I_OR;
        endcase
        a_addr = ir[0 +: RW];
        b_addr = ir[RW +: RW];
        c_addr = ir[2*RW +: RW];
      end
      8'h01: begin decoded = I_BRANCH; mem_addr = ir[ADDR_W-1:0]; end
      8'h02: begin decoded = I_BZERO;  mem_addr = ir[ADDR_W-1:0]; end
      8'h03: begin decoded = I_BNEG;   mem_addr = ir[ADDR_W-1:0]; end
      8'h05: begin decoded = I_BOV;    mem_addr = ir[ADDR_W-1:0]; end
      8'h06: begin decoded = I_BNOV;   mem_addr = ir[ADDR_W-1:0]; end
      8'h0A: begin decoded = I_BNNEG;  mem_addr = ir[ADDR_W-1:0]; end
      8'h0B: begin decoded = I_BNZERO; mem_addr = ir[ADDR_W-1:0]; end
      8'hFF: decoded = I_HALT;
      default: ;
    endcase
  end

  assign bus_a = regs[a_addr];
  assign bus_b = regs[b_addr];

  always_comb begin
    is_sub  = (bus.operation == 2'b01);
    b_op    = is_sub ? ~bus_b : bus_b;
    sum     = {1'b0, bus_a} + {1'b0, b_op} + {{DATA_W{1'b0}}, is_sub};
    alu_res = '0;
    alu_u   = 1'b0;
    alu_s   = 1'b0;
    case (bus.operation)
      2'b00, 2'b01: begin
        alu_res = sum[DATA_W-1:0];
        alu_u   = sum[DATA_W] ^ is_sub;
        // same as carry-into-MSB ^ carry-out: like-signed operands, differently signed result
        alu_s   = (bus_a[DATA_W-1] == b_op[DATA_W-1]) && (sum[DATA_W-1] != bus_a[DATA_W-1]);
      end
      2'b10:   alu_res = bus_a & bus_b;
      default: alu_res = bus_a | bus_b;
    endcase
    alu_z = (alu_res == '0);
    alu_n = alu_res[DATA_W-1];
  end

  assign bus_c = bus.c_sel ? alu_res : bus.data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir     <= '0;
      pc     <= '0;
      regs   <= '{default: '0};
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      uov_q  <= 1'b0;
      sov_q  <= 1'b0;
    end else begin
      if (bus.ir_enable) ir <= bus.data_in;
      if (bus.pc_enable) pc <= bus.branch ? mem_addr : pc + PC_ONE;
      if (bus.write_reg_enable) regs[c_addr] <= bus_c;
      if (bus.flags_reg_enable) begin
        zero_q <= alu_z;
        neg_q  <= alu_n;
        uov_q  <= alu_u;
        sov_q  <= alu_s;
      end
    end
  end

  assign bus.decoded_instruction = decoded;
  assign bus.zero_op             = zero_q;
  assign bus.neg_op              = neg_q;
  assign bus.unsigned_overflow   = uov_q;
  assign bus.signed_overflow     = sov_q;
  assign bus.ram_addr            = bus.addr_sel ? pc : mem_addr;
  assign bus.data_out            = bus_a;
endmodule

// File: tb/tb_ks_datapath_param.sv
// Self-checking bench for ks_datapath_param: vector tables, directed corner sequences, random ops.
module tb_ks_datapath_param;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  ks_datapath_param_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  ks_datapath_param #(.DATA_W(16), .NREGS(4), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [15:0] mreg [4];
  logic [4:0]  mpc;
  logic        mz, mn, mu, ms;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flags;  // {zero, neg, unsigned, signed}
  } alu_vec_t;

  typedef struct {
    logic [15:0]             instr;
    decoded_instruction_type dec;
    logic [4:0]              mem;
  } dec_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void alu_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic z, output logic n,
                                    output logic u, output logic s);
    int unsigned ua, ub, ur;
    int sa, sb, sr;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    u = 1'b0; s = 1'b0; r = '0;
    case (op)
      2'd0: begin ur = ua + ub; r = 16'(ur); u = (ur > 65535); sr = sa + sb; s = (sr > 32767 || sr < -32768); end
      2'd1: begin ur = ua - ub; r = 16'(ur); u = (ua < ub);    sr = sa - sb; s = (sr > 32767 || sr < -32768); end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    z = (r == 16'd0);
    n = r[15];
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.ir_enable = 1'b0;
    bus.pc_enable = 1'b0;
    bus.branch = 1'b0;
    bus.write_reg_enable = 1'b0;
    bus.flags_reg_enable = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    mpc = '0;
    {mz, mn, mu, ms} = 4'b0;
  endtask

  task automatic load_ir(input logic [15:0] instr);
    idle();
    bus.data_in = instr;
    bus.ir_enable = 1'b1;
    tick();
    bus.ir_enable = 1'b0;
  endtask

  task automatic set_reg(input logic [1:0] r, input logic [15:0] v);
    load_ir({8'h81, 1'b0, r, 5'd0});
    bus.c_sel = 1'b0;
    bus.data_in = v;
    bus.write_reg_enable = 1'b1;
    tick();
    bus.write_reg_enable = 1'b0;
    mreg[r] = v;
  endtask

  task automatic check_reg(input string nm, input logic [1:0] r, input logic [15:0] exp);
    load_ir({8'h82, 1'b0, r, 5'd0});
    #1;
    chk(nm, 32'(bus.data_out), 32'(exp));
  endtask

  task automatic alu_op(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic fen);
    logic [15:0] r;
    logic z, n, u, s;
    load_ir({8'hA1 + {6'b0, op}, 2'b00, c, b, a});
    alu_model(op, mreg[a], mreg[b], r, z, n, u, s);
    bus.c_sel = 1'b1;
    bus.operation = op;
    bus.write_reg_enable = 1'b1;
    bus.flags_reg_enable = fen;
    tick();
    idle();
    mreg[c] = r;
    if (fen) {mz, mn, mu, ms} = {z, n, u, s};
  endtask

  function automatic logic [31:0] dut_flags();
    return 32'({bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow});
  endfunction

  alu_vec_t alu_tab [8];
  dec_vec_t dec_tab [11];

  initial begin
    logic [1:0]  ra, rb, rc, op, a_idx, b_idx;
    logic [15:0] v, r;
    logic [4:0]  ma, mem;
    logic        fen, pe, br, z, n, u, s;
    int unsigned kind;

    alu_tab[0] = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
    alu_tab[1] = '{2'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110};
    alu_tab[2] = '{2'd1, 16'h0005, 16'h0005, 16'h0000, 4'b1000};
    alu_tab[3] = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
    alu_tab[4] = '{2'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    alu_tab[5] = '{2'd3, 16'h8000, 16'h0001, 16'h8001, 4'b0100};
    alu_tab[6] = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
    alu_tab[7] = '{2'd2, 16'h1234, 16'h0000, 16'h0000, 4'b1000};

    dec_tab[0]  = '{16'h0215, I_BZERO,  5'h15};
    dec_tab[1]  = '{16'h0B1F, I_BNZERO, 5'h1F};
    dec_tab[2]  = '{16'h0A03, I_BNNEG,  5'h03};
    dec_tab[3]  = '{16'h0504, I_BOV,    5'h04};
    dec_tab[4]  = '{16'h0608, I_BNOV,   5'h08};
    dec_tab[5]  = '{16'h0310, I_BNEG,   5'h10};
    dec_tab[6]  = '{16'hFF00, I_HALT,   5'h00};
    dec_tab[7]  = '{16'h5512, I_NOP,    5'h00};
    dec_tab[8]  = '{16'h0412, I_NOP,    5'h00};
    dec_tab[9]  = '{16'h8127, I_LOAD,   5'h07};
    dec_tab[10] = '{16'hA3FF, I_AND,    5'h00};

    idle();
    bus.addr_sel = 1'b0;
    bus.c_sel = 1'b0;
    bus.operation = 2'b00;
    bus.data_in = '0;
    model_reset();

    // Reset state
    #12;
    chk("reset_dec", 32'(bus.decoded_instruction), 32'(I_NOP));
    chk("reset_mem_addr", 32'(bus.ram_addr), 32'd0);
    bus.addr_sel = 1'b1;
    #1;
    chk("reset_pc", 32'(bus.ram_addr), 32'd0);
    chk("reset_flags", dut_flags(), 32'd0);
    chk("reset_data_out", 32'(bus.data_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU vectors
    foreach (alu_tab[i]) begin
      set_reg(2'd0, alu_tab[i].a);
      set_reg(2'd1, alu_tab[i].b);
      alu_op(alu_tab[i].op, 2'd0, 2'd1, 2'd2, 1'b1);
      #1;
      chk($sformatf("alu_flags[%0d]", i), dut_flags(), 32'(alu_tab[i].flags));
      check_reg($sformatf("alu_res[%0d]", i), 2'd2, alu_tab[i].res);
    end

    // Decode vectors
    bus.addr_sel = 1'b0;
    foreach (dec_tab[i]) begin
      load_ir(dec_tab[i].instr);
      #1;
      chk($sformatf("dec[%0d]", i), 32'(bus.decoded_instruction), 32'(dec_tab[i].dec));
      chk($sformatf("dec_mem[%0d]", i), 32'(bus.ram_addr), 32'(dec_tab[i].mem));
    end

    // Flags hold across ALU activity and register writes
    set_reg(2'd0, 16'hFFFF);
    set_reg(2'd1, 16'h0001);
    alu_op(2'd0, 2'd0, 2'd1, 2'd2, 1'b1);
    #1;
    chk("carry_zero_flags", dut_flags(), 32'b1010);
    alu_op(2'd3, 2'd0, 2'd1, 2'd3, 1'b0);
    #1;
    chk("flags_hold", dut_flags(), 32'b1010);
    check_reg("or_write_no_flags", 2'd3, 16'hFFFF);

    // Write port: same-cycle read returns old value (MOVE R1<-R1 via data_in)
    load_ir(16'h9105);
    bus.c_sel = 1'b0;
    bus.data_in = 16'h5555;
    bus.write_reg_enable = 1'b1;
    #1;
    chk("read_old_on_write", 32'(bus.data_out), 32'h0001);
    tick();
    idle();
    #1;
    chk("read_after_write", 32'(bus.data_out), 32'h5555);
    mreg[1] = 16'h5555;

    // PC branch / wrap
    load_ir(16'h011F);
    bus.pc_enable = 1'b1;
    bus.branch = 1'b1;
    tick();
    idle();
    bus.addr_sel = 1'b1;
    #1;
    chk("pc_branch_31", 32'(bus.ram_addr), 32'd31);
    bus.pc_enable = 1'b1;
    tick();
    idle();
    #1;
    chk("pc_wrap", 32'(bus.ram_addr), 32'd0);
    load_ir(16'h0107);
    bus.pc_enable = 1'b1;
    bus.branch = 1'b1;
    tick();
    idle();
    #1;
    chk("pc_branch_7", 32'(bus.ram_addr), 32'd7);
    bus.addr_sel = 1'b0;
    #1;
    chk("mem_addr_7", 32'(bus.ram_addr), 32'd7);

    // LOAD R3,[9] then STORE R3,[4]
    load_ir(16'h8169);
    #1;
    chk("load_dec", 32'(bus.decoded_instruction), 32'(I_LOAD));
    chk("load_addr", 32'(bus.ram_addr), 32'd9);
    bus.c_sel = 1'b0;
    bus.data_in = 16'hBEEF;
    bus.write_reg_enable = 1'b1;
    tick();
    idle();
    mreg[3] = 16'hBEEF;
    load_ir(16'h8264);
    #1;
    chk("store_addr", 32'(bus.ram_addr), 32'd4);
    chk("store_data", 32'(bus.data_out), 32'hBEEF);

    // Asynchronous reset mid-run
    set_reg(2'd1, 16'h1234);
    set_reg(2'd0, 16'hFFFF);
    alu_op(2'd0, 2'd0, 2'd1, 2'd2, 1'b1);
    load_ir(16'h010D);
    bus.pc_enable = 1'b1;
    bus.branch = 1'b1;
    tick();
    idle();
    bus.addr_sel = 1'b1;
    #1;
    chk("pre_reset_pc", 32'(bus.ram_addr), 32'd13);
    chk("pre_reset_flags", dut_flags(), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pc", 32'(bus.ram_addr), 32'd0);
    chk("async_reset_dec", 32'(bus.decoded_instruction), 32'(I_NOP));
    chk("async_reset_flags", dut_flags(), 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_reg("reset_r1", 2'd1, 16'h0000);
    check_reg("reset_r2", 2'd2, 16'h0000);

    // Random operations against the reference model
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 2);
      ra = 2'($urandom); rb = 2'($urandom); rc = 2'($urandom); op = 2'($urandom);
      v = 16'($urandom); ma = 5'($urandom);
      fen = 1'($urandom); pe = 1'($urandom); br = 1'($urandom);
      if (kind == 0) begin
        load_ir({8'h81, 1'b0, rc, ma});
        mem = ma; a_idx = 2'd0; b_idx = 2'd0;
      end else if (kind == 1) begin
        load_ir({8'hA1 + {6'b0, op}, 2'b00, rc, rb, ra});
        mem = '0; a_idx = ra; b_idx = rb;
      end else begin
        load_ir({8'h91, 4'b0, rc, ra});
        mem = '0; a_idx = ra; b_idx = ra;
      end
      bus.c_sel = (kind != 0);
      bus.operation = op;
      bus.data_in = v;
      bus.write_reg_enable = 1'b1;
      bus.flags_reg_enable = fen;
      bus.pc_enable = pe;
      bus.branch = br;
      bus.addr_sel = 1'b1;
      #1;
      chk("rand_bus_a", 32'(bus.data_out), 32'(mreg[a_idx]));
      alu_model(op, mreg[a_idx], mreg[b_idx], r, z, n, u, s);
      tick();
      idle();
      mreg[rc] = (kind == 0) ? v : r;
      if (fen) {mz, mn, mu, ms} = {z, n, u, s};
      if (pe) mpc = br ? mem : mpc + 5'd1;
      #1;
      chk("rand_pc", 32'(bus.ram_addr), 32'(mpc));
      chk("rand_flags", dut_flags(), 32'({mz, mn, mu, ms}));
      if (it % 16 == 15)
        for (int k = 0; k < 4; k++) check_reg($sformatf("rand_reg%0d", k), 2'(k), mreg[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
